// File: rtl/rs_syndrome_gen_if.sv
// Symbol input and syndrome output bundle of the RS syndrome generator.
// The master drives symbols in and receives the syndrome bank back.
interface rs_syndrome_gen_if #(
  parameter int unsigned NPAR = 8
);
  logic                 din_val;
  logic                 din_sop;
  logic                 din_eop;
  logic [7:0]           din;
  logic                 syn_val;
  logic [8*NPAR-1:0]    syn;
  logic                 syn_zero;
  logic                 len_err;

  modport master (
    output din_val, din_sop, din_eop, din,
    input  syn_val, syn, syn_zero, len_err
  );

  modport slave (
    input  din_val, din_sop, din_eop, din,
    output syn_val, syn, syn_zero, len_err
  );
endinterface

// File: rtl/rs_syndrome_gen.sv
// Reed-Solomon syndrome generator over GF(2^8), poly 0x11D, Horner accumulators
// with a held output bank, codeword length checking and a no-error flag.
module rs_syndrome_gen #(
  parameter int unsigned NPAR = 8,
  parameter int unsigned FCR  = 1,
  parameter int unsigned NSYM = 255
) (
  input logic              clk,
  input logic              rst,
  rs_syndrome_gen_if.slave bus
);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  localparam logic [7:0] NSYM_B = 8'(NSYM);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // With a constant b this folds to a pure XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] alpha_pow(input int unsigned e);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned k = 0; k < e % 255; k++) r = gf_xtime(r);
    return r;
  endfunction

  state_t                 state_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [NPAR-1:0][7:0]   acc_q, acc_d, prod;
  logic                   syn_val_q;
  logic [8*NPAR-1:0]      syn_q;
  logic                   syn_zero_q;
  logic                   len_err_q;

  logic in_frame, take_sop, take_sym, frame_eop, stray_eop, len_bad;

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_root
    localparam logic [7:0] ROOT = alpha_pow(FCR + gi);
    always_comb prod[gi] = gf_mul(acc_q[gi], ROOT);
  end

  always_comb begin
    in_frame  = (state_q == S_FRAME);
    take_sop  = bus.din_val & bus.din_sop;
    take_sym  = bus.din_val & (bus.din_sop | in_frame);
    frame_eop = take_sym & bus.din_eop;
    stray_eop = bus.din_val & bus.din_eop & ~bus.din_sop & ~in_frame;

    cnt_d = cnt_q;
    if (take_sop)                 cnt_d = 8'd1;
    else if (take_sym && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

    acc_d = acc_q;
    for (int unsigned i = 0; i < NPAR; i++) begin
      if (take_sop)      acc_d[i] = bus.din;
      else if (take_sym) acc_d[i] = prod[i] ^ bus.din;
    end

    len_bad = (cnt_d != NSYM_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      syn_val_q  <= 1'b0;
      syn_q      <= '0;
      syn_zero_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      if (take_sop && !bus.din_eop) state_q <= S_FRAME;
      else if (frame_eop)           state_q <= S_IDLE;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      syn_val_q <= frame_eop;
      if (frame_eop) begin
        syn_q      <= acc_d;
        len_err_q  <= len_bad;
        syn_zero_q <= (acc_d == '0) & ~len_bad;
      end else if (stray_eop) begin
        len_err_q  <= 1'b1;
        syn_zero_q <= 1'b0;
      end
    end
  end

  assign bus.syn_val  = syn_val_q;
  assign bus.syn      = syn_q;
  assign bus.syn_zero = syn_zero_q;
  assign bus.len_err  = len_err_q;

endmodule

// File: doc/rs_syndrome_gen.md
# rs_syndrome_gen

Parametrised Reed-Solomon syndrome generator over GF(2^8), primitive polynomial 0x11D. It is the next generation of the fixed RS(255,247) eight-syndrome stage: the number of syndromes, the first consecutive root and the codeword length are configurable. It adds a held output bank so frames can arrive back-to-back, codeword-length checking and an all-zero (no-error) flag. It sits between the symbol input framing and the key-equation solver in the RS decoder.

## Interface
- NPAR, 8, number of syndromes (2T); legal 2..32
- FCR, 1, exponent of the first consecutive root; syndrome i uses root alpha^(FCR+i), i = 0..NPAR-1
- NSYM, 255, expected codeword length in symbols; legal 1..255
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- din_val  in  1  input symbol valid
- din_sop  in  1  first symbol of codeword; qualified by din_val
- din_eop  in  1  last symbol of codeword; qualified by din_val
- din  in  8  symbol; the first symbol is the highest-degree coefficient r_(n-1)
- syn_val  out  1  one-cycle pulse: syn/syn_zero/len_err valid
- syn  out  8*NPAR  syndrome bank; S_i at bits [8i+7:8i]
- syn_zero  out  1  all NPAR syndromes are 0 and the length is correct
- len_err  out  1  completed frame length != NSYM, or eop seen outside a frame; pulses with or without syn_val

## Operation
- Root constants alpha^(FCR+i) are computed at elaboration. Each multiplier is a constant GF(2^8) multiplier: an XOR network with no lookup RAM.
- Accumulators acc_i use Horner form. On an accepted sop: acc_i <= din. On other accepted symbols inside a frame: acc_i <= acc_i*alpha^(FCR+i) ^ din.
- Symbol counter (8 bits, saturating at 255):
  - sop loads 1.
  - Each later accepted symbol increments it.
- in_frame flag:
  - Set by sop.
  - Cleared by eop.
  - sop with eop in the same cycle is a one-symbol frame; in_frame stays 0.
- sop while in_frame aborts the open frame silently; the new frame starts from din.
- din_val=1 with no sop and in_frame=0 is ignored, except that an eop here pulses len_err with no syn_val.
- At an accepted eop of a valid frame:
  - The final acc_i values, including the eop symbol, are written to the syn bank.
  - len_err = (count incl. eop != NSYM).
  - syn_zero = all final acc_i == 0 and length OK.
  - syn_val pulses.
- syn holds its value until the next eop capture. syn_zero and len_err also hold until the next syn_val or len_err pulse.
- din_val=0 cycles inside a frame freeze the accumulators and the counter (gaps allowed).
- Reset values:
  - syn = 0, syn_val = 0, syn_zero = 0, len_err = 0.
  - Accumulators 0, counter 0, in_frame 0.
- Reset mid-frame discards the frame. No syn_val is produced for it.

## Timing
- Latency: syn_val is asserted in the cycle after the cycle in which din_val & din_eop is sampled. syn, syn_zero and len_err are updated on the same edge.
- Back-to-back: a sop in the cycle right after eop is accepted. The accumulators reload while the syn bank shows the previous frame. Full throughput is one symbol per clock with zero idle cycles between frames.
- eop and a new frame cannot overlap. Input framing guarantees sop is never asserted together with the eop of a previous frame; sop&eop together means a one-symbol frame only.
- Critical path: one constant multiply plus an XOR, from register to register.

## Test plan
- All-zero codeword, 255 symbols, NPAR=8, FCR=1 -> one cycle after eop: syn_val=1, every S_i=0x00, syn_zero=1, len_err=0.
- 255 symbols, all 0x00 except the last symbol = 0x01 -> every S_i=0x01, syn_zero=0. Same test with the second-to-last symbol = 0x01 instead -> S_0..S_7 = 02,04,08,10,20,40,80,1D.
- Two back-to-back frames with no gap: frame A is all zero, frame B has the last symbol 0x01. Required: syn_val is pulsed exactly twice, 255 cycles apart. Bank shows A's values until B's capture.
- Frame of 255 symbols with random din_val gaps (about 30% idle), compared against a software model of random codewords plus 1–4 injected errors -> syn matches bit-exactly.
- Length and framing errors:
  - 254-symbol frame -> syn_val=1, len_err=1, syn_zero=0.
  - Stray eop with no frame open -> len_err=1, syn_val=0, syn unchanged.
  - sop at symbol 100 of an open frame -> only the restarted frame is reported.
- rst asserted at symbol 128 -> all outputs are 0 immediately (asynchronous). No syn_val follows. The next full frame is computed correctly.
- Parameter sweep NPAR=16, FCR=0 -> all-zero codeword gives syn_zero=1. With a single 0x01 on the last symbol, all 16 syndromes = 0x01.
